pass_check_prog: RTL and testbench

- Next-generation password checker. Accepts a character stream, compares it against a stored password of programmable length, and grants access on a correct submit.
- Adds three things: a runtime-programmable password, explicit submit and close, and a failed-attempt counter with timed lockout.
- Sits between the keypad/UART character source and the door/unlock logic.

---
 rtl/pass_check_prog_if.sv | 35 +++
 rtl/pass_check_prog.sv | 183 ++++++++++++++++++
 tb/tb_pass_check_prog.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pass_check_prog_if.sv
// pass_check_prog_if: character stream, programming and status signals of the
// password checker. The master side (character source / door logic) drives
// the inputs; the slave side (the checker) returns status.
interface pass_check_prog_if #(
  parameter int DATA_W    = 8,
  parameter int MAX_LEN   = 8,
  parameter int MAX_TRIES = 3
);
  localparam int PIDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int CNT_W  = $clog2(MAX_TRIES + 1);

  logic              en;
  logic [DATA_W-1:0] data_in;
  logic              close;
  logic              prog_we;
  logic [PIDX_W-1:0] prog_idx;
  logic [DATA_W-1:0] prog_data;
  logic              prog_len_we;
  logic [LEN_W-1:0]  prog_len;
  logic              pass_ok;
  logic              fail_pulse;
  logic              locked;
  logic [CNT_W-1:0]  fail_cnt;

  modport master (
    output en, data_in, close, prog_we, prog_idx, prog_data, prog_len_we, prog_len,
    input  pass_ok, fail_pulse, locked, fail_cnt
  );

  modport slave (
    input  en, data_in, close, prog_we, prog_idx, prog_data, prog_len_we, prog_len,
    output pass_ok, fail_pulse, locked, fail_cnt
  );
endinterface

// File: rtl/pass_check_prog.sv
// pass_check_prog: password checker with a runtime-programmable password,
// explicit submit/close and a failed-attempt counter.
// Optional lockout: define PASS_CHECK_LOCKOUT_EN to build the LOCK state and
// its timer; otherwise fail_cnt saturates at MAX_TRIES and locked stays 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// ENTRY | collecting characters; submit char ends an attempt
// OPEN  | access granted; password/length may be reprogrammed
// LOCK  | too many failed submits; everything ignored until timer ends
module pass_check_prog #(
  parameter int              DATA_W      = 8,
  parameter int              MAX_LEN     = 8,
  parameter int              MAX_TRIES   = 3,
  parameter int              LOCK_CYCLES = 16,
  parameter logic [DATA_W-1:0] SUBMIT_CHAR = DATA_W'(8'h0D)
) (
  input logic              clock,
  input logic              reset,
  pass_check_prog_if.slave bus
);

  localparam int PIDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int CNT_W  = $clog2(MAX_TRIES + 1);

  localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] TRIES   = CNT_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ENTRY = 2'd0;
  localparam logic [1:0] OPEN  = 2'd1;
`ifdef PASS_CHECK_LOCKOUT_EN
  localparam logic [1:0] LOCK  = 2'd2;
  localparam int         TMR_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
`endif

  // Factory password "teoro", unused slots zero.
  function automatic logic [DATA_W-1:0] default_pw(input int i);
    case (i)
      0:       return DATA_W'(8'h74);
      1:       return DATA_W'(8'h65);
      2:       return DATA_W'(8'h6F);
      3:       return DATA_W'(8'h72);
      4:       return DATA_W'(8'h6F);
      default: return '0;
    endcase
  endfunction

  logic [1:0]        state_q,      state_d;
  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic              match_q,      match_d;
  logic [CNT_W-1:0]  fail_cnt_q,   fail_cnt_d;
  logic              fail_pulse_q, fail_pulse_d;
  logic [IDX_W-1:0]  pw_len_q,     pw_len_d;
  logic [DATA_W-1:0] pw_q [MAX_LEN];
  logic [DATA_W-1:0] pw_d [MAX_LEN];
`ifdef PASS_CHECK_LOCKOUT_EN
  logic [TMR_W-1:0]  timer_q,      timer_d;
`endif

  logic submit_ok;

  // Next-state and datapath decisions for all three states.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    match_d      = match_q;
    fail_cnt_d   = fail_cnt_q;
    fail_pulse_d = 1'b0;
    pw_len_d     = pw_len_q;
    pw_d         = pw_q;
`ifdef PASS_CHECK_LOCKOUT_EN
    timer_d      = timer_q;
`endif
    submit_ok    = match_q && (idx_q == pw_len_q) && (pw_len_q != '0);

    case (state_q)
      ENTRY: begin
        if (bus.en) begin
          if (bus.data_in == SUBMIT_CHAR) begin
            idx_d   = '0;
            match_d = 1'b1;
            if (submit_ok) begin
              state_d    = OPEN;
              fail_cnt_d = '0;
            end else begin
              fail_pulse_d = 1'b1;
`ifdef PASS_CHECK_LOCKOUT_EN
              fail_cnt_d = fail_cnt_q + CNT_ONE;
              if (fail_cnt_q + CNT_ONE == TRIES) begin
                state_d = LOCK;
                timer_d = TMR_LOAD;
              end
`else
              if (fail_cnt_q != TRIES) begin
                fail_cnt_d = fail_cnt_q + CNT_ONE;
              end
`endif
            end
          end else if (idx_q < LEN_MAX) begin
            match_d = match_q && (bus.data_in == pw_q[idx_q[PIDX_W-1:0]]);
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            // Entry longer than any possible password can never succeed.
            match_d = 1'b0;
          end
        end
      end

      OPEN: begin
        if (bus.prog_we && (int'(bus.prog_idx) < MAX_LEN)) begin
          pw_d[bus.prog_idx] = bus.prog_data;
        end
        if (bus.prog_len_we && (bus.prog_len <= LEN_MAX)) begin
          pw_len_d = bus.prog_len;
        end
        if (bus.close) begin
          state_d = ENTRY;
        end
      end

`ifdef PASS_CHECK_LOCKOUT_EN
      LOCK: begin
        if (timer_q == TMR_ONE) begin
          state_d    = ENTRY;
          fail_cnt_d = '0;
          timer_d    = '0;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
`endif

      default: begin
        state_d = ENTRY;
        idx_d   = '0;
        match_d = 1'b1;
      end
    endcase
  end

  // State registers; reset restores the factory password and length.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ENTRY;
      idx_q        <= '0;
      match_q      <= 1'b1;
      fail_cnt_q   <= '0;
      fail_pulse_q <= 1'b0;
      pw_len_q     <= IDX_W'(5);
      for (int i = 0; i < MAX_LEN; i++) begin
        pw_q[i] <= default_pw(i);
      end
`ifdef PASS_CHECK_LOCKOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      match_q      <= match_d;
      fail_cnt_q   <= fail_cnt_d;
      fail_pulse_q <= fail_pulse_d;
      pw_len_q     <= pw_len_d;
      pw_q         <= pw_d;
`ifdef PASS_CHECK_LOCKOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  assign bus.pass_ok    = (state_q == OPEN);
  assign bus.fail_pulse = fail_pulse_q;
  assign bus.fail_cnt   = fail_cnt_q;
`ifdef PASS_CHECK_LOCKOUT_EN
  assign bus.locked     = (state_q == LOCK);
`else
  assign bus.locked     = 1'b0;
`endif

endmodule

// File: tb/tb_pass_check_prog.sv
// tb_pass_check_prog: directed stimulus with a character-buffer model of the
// password checker, per-cycle output comparison and literal spot checks.
module tb_pass_check_prog;
  localparam int DATA_W      = 8;
  localparam int MAX_LEN     = 8;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 16;
  localparam logic [7:0] CR  = 8'h0D;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  pass_check_prog_if #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .MAX_TRIES(MAX_TRIES)) bus ();

  pass_check_prog #(
    .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .MAX_TRIES(MAX_TRIES),
    .LOCK_CYCLES(LOCK_CYCLES), .SUBMIT_CHAR(CR)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Model: the attempt is kept as a plain list of typed characters and judged
  // as a whole on submit.
  bit        m_open = 0;
  int        m_lock_left = 0;
  int        m_fail_cnt = 0;
  bit        m_fail_pulse = 0;
  byte       m_pw [MAX_LEN];
  int        m_len = 5;
  byte       m_buf [$];
  bit        m_over = 0;

  task automatic model_reset();
    m_open = 0; m_lock_left = 0; m_fail_cnt = 0; m_fail_pulse = 0;
    m_pw = '{8'h74, 8'h65, 8'h6F, 8'h72, 8'h6F, 8'h00, 8'h00, 8'h00};
    m_len = 5; m_buf.delete(); m_over = 0;
  endtask

  function automatic bit attempt_good();
    if (m_over || m_len == 0 || m_buf.size() != m_len) return 0;
    for (int i = 0; i < m_len; i++) if (m_buf[i] != m_pw[i]) return 0;
    return 1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      model_reset();
    end else begin
      m_fail_pulse = 0;
      if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0) m_fail_cnt = 0;
      end else if (m_open) begin
        if (bus.prog_we && int'(bus.prog_idx) < MAX_LEN) m_pw[bus.prog_idx] = bus.prog_data;
        if (bus.prog_len_we && int'(bus.prog_len) <= MAX_LEN) m_len = int'(bus.prog_len);
        if (bus.close) m_open = 0;
      end else if (bus.en) begin
        if (bus.data_in == CR) begin
          if (attempt_good()) begin
            m_open = 1; m_fail_cnt = 0;
          end else begin
            m_fail_pulse = 1;
`ifdef PASS_CHECK_LOCKOUT_EN
            m_fail_cnt++;
            if (m_fail_cnt == MAX_TRIES) m_lock_left = LOCK_CYCLES;
`else
            if (m_fail_cnt < MAX_TRIES) m_fail_cnt++;
`endif
          end
          m_buf.delete(); m_over = 0;
        end else if (m_buf.size() < MAX_LEN) begin
          m_buf.push_back(bus.data_in);
        end else begin
          m_over = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_pass_ok",    int'(bus.pass_ok),    int'(m_open));
      chk("cyc_fail_pulse", int'(bus.fail_pulse), int'(m_fail_pulse));
      chk("cyc_locked",     int'(bus.locked),     int'(m_lock_left > 0));
      chk("cyc_fail_cnt",   int'(bus.fail_cnt),   m_fail_cnt);
    end
  end

  // Length of the most recent completed run of locked cycles.
  int lock_run = 0;
  int last_run = 0;
  always @(negedge clock) begin
    if (bus.locked === 1'b1) lock_run++;
    else begin
      if (lock_run > 0) last_run = lock_run;
      lock_run = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input byte c);
    bus.en = 1'b1; bus.data_in = c;
    tick();
    bus.en = 1'b0;
  endtask

  task automatic attempt(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
    send(CR);
  endtask

  task automatic do_close();
    bus.close = 1'b1;
    tick();
    bus.close = 1'b0;
  endtask

  task automatic prog(input bit we, input int idx, input byte d,
                      input bit lwe, input int len, input bit cl);
    bus.prog_we = we; bus.prog_idx = 3'(idx); bus.prog_data = d;
    bus.prog_len_we = lwe; bus.prog_len = 4'(len); bus.close = cl;
    tick();
    bus.prog_we = 0; bus.prog_len_we = 0; bus.close = 0;
  endtask

  task automatic wait_unlock();
    int n = 0;
    while (bus.locked !== 1'b0 && n < 60) begin
      tick(); n++;
    end
    chk("lock_release_timeout", int'(n < 60), 1);
  endtask

  initial begin
    bus.en = 0; bus.data_in = '0; bus.close = 0;
    bus.prog_we = 0; bus.prog_idx = '0; bus.prog_data = '0;
    bus.prog_len_we = 0; bus.prog_len = '0;
    reset = 1'b1;
    tick(2);
    chk_en = 1'b1;
    reset = 1'b0;
    chk("rst_pass_ok", int'(bus.pass_ok), 0);
    chk("rst_fail_cnt", int'(bus.fail_cnt), 0);
    chk("rst_locked", int'(bus.locked), 0);

    attempt("teoro");
    chk("default_open", int'(bus.pass_ok), 1);
    chk("default_cnt", int'(bus.fail_cnt), 0);
    do_close();
    chk("close_entry", int'(bus.pass_ok), 0);

    attempt("teor");
    chk("short_pulse", int'(bus.fail_pulse), 1);
    chk("short_cnt", int'(bus.fail_cnt), 1);
    tick();
    chk("pulse_one_cycle", int'(bus.fail_pulse), 0);
    chk("short_not_open", int'(bus.pass_ok), 0);
    attempt("teoroo");
    chk("long_cnt", int'(bus.fail_cnt), 2);
    tick(2);
    attempt("teoroteor");
    chk("overflow_cnt", int'(bus.fail_cnt), 3);
`ifdef PASS_CHECK_LOCKOUT_EN
    chk("lock_on", int'(bus.locked), 1);
    attempt("teoro");
    chk("lock_ignores_entry", int'(bus.pass_ok), 0);
    wait_unlock();
    tick();
    chk("lock_len", last_run, LOCK_CYCLES);
    chk("lock_clears_cnt", int'(bus.fail_cnt), 0);
`else
    chk("no_lock", int'(bus.locked), 0);
    attempt("x");
    chk("sat_cnt", int'(bus.fail_cnt), 3);
    chk("sat_no_lock", int'(bus.locked), 0);
`endif
    attempt("teoro");
    chk("reopen", int'(bus.pass_ok), 1);
    chk("reopen_cnt", int'(bus.fail_cnt), 0);

    prog(0, 0, 0, 1, 9, 0);
    prog(1, 0, "a", 0, 0, 0);
    prog(1, 1, "b", 1, 2, 0);
    do_close();
    attempt("teoro");
    chk("old_pw_fails", int'(bus.fail_cnt), 1);
    attempt("ab");
    chk("new_pw_opens", int'(bus.pass_ok), 1);

    prog(1, 2, "c", 1, 3, 1);
    chk("close_with_prog", int'(bus.pass_ok), 0);
    prog(1, 0, "z", 1, 1, 0);
    attempt("abc");
    chk("prog_applied_on_close", int'(bus.pass_ok), 1);

    prog(0, 0, 0, 1, 0, 1);
    send(CR);
    chk("len0_empty_fails", int'(bus.fail_pulse), 1);
    attempt("abc");
    chk("len0_fails", int'(bus.fail_cnt), 2);
    chk("len0_not_open", int'(bus.pass_ok), 0);
    attempt("q");
`ifdef PASS_CHECK_LOCKOUT_EN
    chk("lock_again", int'(bus.locked), 1);
`endif
    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_lock_off", int'(bus.locked), 0);
    chk("rst_cnt_clear", int'(bus.fail_cnt), 0);
    attempt("teoro");
    chk("rst_default_pw", int'(bus.pass_ok), 1);
    do_close();

    send("t"); send("e"); send("o");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    attempt("ro");
    chk("mid_reset_discards", int'(bus.pass_ok), 0);
    chk("mid_reset_cnt", int'(bus.fail_cnt), 1);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected end before 200000");
    $fatal(1, "timeout");
  end
endmodule
